timer_alarm: RTL and testbench
==============================

# timer_alarm

Compare/alarm stage sitting directly downstream of `timer_core`. It consumes the free-running 64-bit `TIMER_VALUE` and raises a level interrupt when the counter reaches a programmed 64-bit compare value. It supports one-shot and periodic (auto-reload) modes and counts overruns. Software-register writes arrive as 32-bit halves from the peripheral register file.

## Interface
- `DATA_W`, 32, register data width; the compare and period values are `2*DATA_W` bits wide.
- `OVR_W`, 8, width of the saturating overrun counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset. This is the combined hard/soft timer reset.
- `timer_value`  in  2*DATA_W  counter from `timer_core`, registered at source.
- `wdata`  in  DATA_W  write data shared by the four write enables below.
- `cmp_lo_we`, `cmp_hi_we`  in  1 each  write `wdata` into the compare value, bits [31:0] and [63:32] respectively.
- `per_lo_we`, `per_hi_we`  in  1 each  write `wdata` into the period, bits [31:0] and [63:32] respectively.
- `periodic`  in  1  level; 1 selects auto-reload mode.
- `arm`  in  1  single-cycle pulse that arms the alarm.
- `disarm`  in  1  single-cycle pulse that returns the block to idle.
- `irq_clr`  in  1  single-cycle pulse that clears the pending interrupt.
- `irq`  out  1  pending interrupt, level.
- `state`  out  2  current FSM state.
- `cmp_value`  out  2*DATA_W  current compare value, for readback.
- `overrun`  out  OVR_W  count of fire events that occurred while `irq` was already pending; saturating.

## Operation
- States:
  - IDLE=0: no compare is evaluated.
  - ARMED=1: compare is evaluated every cycle.
  - FIRED=2: one-shot has completed.
- `arm` moves IDLE, ARMED or FIRED to ARMED. `disarm` moves any state to IDLE and leaves `irq` unchanged. If `arm` and `disarm` are high in the same cycle, `disarm` wins.
- Hit condition, evaluated only in ARMED: `diff = timer_value - cmp_value` (modulo 2^64). A hit occurs when `diff[63]==0`.
  - This is wrap-safe: the counter is at or past the compare value within a half-range.
  - If the timer is soft-reset behind the compare value, no hit occurs until the counter catches up.
- On a hit:
  - `irq<=1`.
  - If `irq` was already 1, `overrun<=overrun+1`, saturating at 2^OVR_W-1.
  - One-shot (`periodic==0`) or period==0: go to FIRED.
  - Periodic with nonzero period: stay in ARMED and set `cmp_value<=cmp_value+period` (modulo 2^64).
- `irq_clr` sets `irq<=0`, except when a hit occurs in the same cycle; then `irq` stays 1 and `overrun` is not incremented.
- Half-word writes take effect at the next edge in any state. If a `cmp_*_we` coincides with a periodic reload, the write wins for the written half; the unwritten half takes the reloaded value.
- `overrun` clears only on `rst`.

## Timing
- Reset values: `state`=IDLE, `irq`=0, `cmp_value`=0, period=0, `overrun`=0.
- Hit-to-`irq` latency: 1 cycle. The `timer_value` sampled in cycle n produces `irq`=1 in cycle n+1.
- The earliest fire after `arm` is 2 cycles: the block enters ARMED at n+1, the compare is evaluated in n+1, and `irq` rises at n+2. This holds even if the compare value is already passed.
- A periodic reload is visible on `cmp_value` in the cycle after the hit. The next hit can occur no earlier than one cycle later.
- `rst` asserted mid-operation forces all reset values at the next edge, overriding every other input.
- There are no combinational paths from inputs to outputs.

## Structure
- The shared timer header holds:
  - state encodings `TIMER_ALARM_IDLE`/`ARMED`/`FIRED`;
  - `TIMER_ALARM_STATE_W`=2;
  - the default `OVR_W`.
- One sub-module is natural: `timer_alarm_cmp`, the combinational wrap-safe 64-bit subtract/hit detect plus the reload adder.
- The FSM, registers and overrun counter stay in `timer_alarm`.

## Test plan
- Reset, write compare value=100 (lo=100, hi=0), one-shot, `arm` at value 10 -> `irq` rises in the cycle after `timer_value`=100; `state`=FIRED; `overrun`=0.
- Periodic, compare=50, period=20, never clear -> hits at 50, 70 and 90; `cmp_value` goes 70, 90, 110; `overrun`=2 after the third hit.
- Compare=5, `arm` when `timer_value`=1000 -> `irq` exactly 2 cycles after `arm`.
- Compare=0xFFFF_FFFF_FFFF_FFF0, periodic, period=0x20, counter crossing 2^64 -> hits at ...FFF0 and at 0x10 after wrap; no spurious hit at wrap.
- `irq_clr` coinciding with a hit -> `irq` stays 1 and `overrun` unchanged. `arm`+`disarm` in the same cycle -> IDLE.
- `rst` asserted while ARMED with `irq`=1 and `overrun`=3 -> all outputs return to reset values next cycle; a later timer pass of the old compare value produces no `irq`.

Source files
------------

// File: rtl/timer_alarm_pkg.sv
// Shared timer header: alarm FSM state encodings and default widths.
package timer_alarm_pkg;

  localparam int TIMER_ALARM_STATE_W = 2;
  localparam int TIMER_ALARM_OVR_W   = 8;

  typedef enum logic [TIMER_ALARM_STATE_W-1:0] {
    TIMER_ALARM_IDLE  = 2'd0,
    TIMER_ALARM_ARMED = 2'd1,
    TIMER_ALARM_FIRED = 2'd2
  } timer_alarm_state_e;

endpackage

// File: rtl/timer_alarm_cmp.sv
// Wrap-safe compare and reload adder for the timer alarm.
// Ports:
//   timer_value  - free-running counter value
//   cmp_value    - programmed compare value
//   period       - auto-reload period
//   hit          - counter is at or past cmp_value within a half-range
//   reload_value - cmp_value + period (modulo 2^W)
module timer_alarm_cmp #(
  parameter int W = 64
) (
  input  logic [W-1:0] timer_value,
  input  logic [W-1:0] cmp_value,
  input  logic [W-1:0] period,
  output logic         hit,
  output logic [W-1:0] reload_value
);

  logic [W-1:0] diff;

  always_comb begin
    diff         = timer_value - cmp_value;
    // Sign bit of the modular difference clear means "not behind".
    hit          = ($signed(diff) >= 0);
    reload_value = cmp_value + period;
  end

endmodule

// File: rtl/timer_alarm.sv
// Compare/alarm stage downstream of timer_core.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   timer_value         - 2*DATA_W counter from timer_core
//   wdata               - register write data (half-word)
//   cmp_lo_we/cmp_hi_we - write low/high half of compare value
//   per_lo_we/per_hi_we - write low/high half of period
//   periodic            - 1 selects auto-reload mode
//   arm, disarm         - single-cycle control pulses
//   irq_clr             - single-cycle pulse clearing pending irq
//   irq                 - pending interrupt (level)
//   state               - current FSM state
//   cmp_value           - compare value readback
//   overrun             - saturating count of hits while irq pending
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OVR_W  = TIMER_ALARM_OVR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2*DATA_W-1:0]            timer_value,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           cmp_lo_we,
  input  logic                           cmp_hi_we,
  input  logic                           per_lo_we,
  input  logic                           per_hi_we,
  input  logic                           periodic,
  input  logic                           arm,
  input  logic                           disarm,
  input  logic                           irq_clr,
  output logic                           irq,
  output logic [TIMER_ALARM_STATE_W-1:0] state,
  output logic [2*DATA_W-1:0]            cmp_value,
  output logic [OVR_W-1:0]               overrun
);

  localparam int VW = 2 * DATA_W;

  timer_alarm_state_e state_q, state_d;
  logic [VW-1:0]      cmp_q, cmp_d;
  logic [VW-1:0]      per_q, per_d;
  logic               irq_q, irq_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;

  logic               raw_hit;
  logic               hit;
  logic               do_reload;
  logic [VW-1:0]      reload_value;

  timer_alarm_cmp #(.W(VW)) u_cmp (
    .timer_value  (timer_value),
    .cmp_value    (cmp_q),
    .period       (per_q),
    .hit          (raw_hit),
    .reload_value (reload_value)
  );

  always_comb begin
    hit       = (state_q == TIMER_ALARM_ARMED) && raw_hit;
    do_reload = hit && periodic && (per_q != '0);

    state_d = state_q;
    if (hit) begin
      state_d = do_reload ? TIMER_ALARM_ARMED : TIMER_ALARM_FIRED;
    end
    if (arm) begin
      state_d = TIMER_ALARM_ARMED;
    end
    if (disarm) begin
      state_d = TIMER_ALARM_IDLE;
    end

    // Register writes land after the reload so the written half wins.
    cmp_d = do_reload ? reload_value : cmp_q;
    if (cmp_lo_we) cmp_d[DATA_W-1:0]  = wdata;
    if (cmp_hi_we) cmp_d[VW-1:DATA_W] = wdata;

    per_d = per_q;
    if (per_lo_we) per_d[DATA_W-1:0]  = wdata;
    if (per_hi_we) per_d[VW-1:DATA_W] = wdata;

    irq_d = irq_q;
    if (hit) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end

    // A hit coinciding with irq_clr is treated as the fresh interrupt.
    ovr_d = ovr_q;
    if (hit && irq_q && !irq_clr && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TIMER_ALARM_IDLE;
      cmp_q   <= '0;
      per_q   <= '0;
      irq_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      per_q   <= per_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign irq       = irq_q;
  assign state     = state_q;
  assign cmp_value = cmp_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_timer_alarm.sv
module tb_timer_alarm;

  logic        clk;
  logic        rst;
  logic [63:0] timer_value;
  logic [31:0] wdata;
  logic        cmp_lo_we, cmp_hi_we, per_lo_we, per_hi_we;
  logic        periodic, arm, disarm, irq_clr;
  logic        irq;
  logic [1:0]  state;
  logic [63:0] cmp_value;
  logic [7:0]  overrun;

  int vectors = 0;
  int errors  = 0;

  // Reference model: state 0 idle, 1 armed, 2 fired.
  logic [1:0]  m_state;
  logic        m_irq;
  logic [63:0] m_cmp;
  logic [63:0] m_per;
  logic [7:0]  m_ovr;

  timer_alarm #(.DATA_W(32), .OVR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .timer_value (timer_value),
    .wdata       (wdata),
    .cmp_lo_we   (cmp_lo_we),
    .cmp_hi_we   (cmp_hi_we),
    .per_lo_we   (per_lo_we),
    .per_hi_we   (per_hi_we),
    .periodic    (periodic),
    .arm         (arm),
    .disarm      (disarm),
    .irq_clr     (irq_clr),
    .irq         (irq),
    .state       (state),
    .cmp_value   (cmp_value),
    .overrun     (overrun)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Advance one clock: model computes its next values from the inputs
  // held across the edge, DUT is sampled 1ns after the edge, pulses drop.
  task automatic tick();
    logic [1:0]  ns;
    logic        ni, hit, rl;
    logic [63:0] nc, np;
    logic [7:0]  no;
    hit = (m_state == 2'd1) && ((timer_value - m_cmp) < 64'h8000_0000_0000_0000);
    rl  = hit && periodic && (m_per != 64'd0);
    nc  = rl ? m_cmp + m_per : m_cmp;
    if (cmp_lo_we) nc = {nc[63:32], wdata};
    if (cmp_hi_we) nc = {wdata, nc[31:0]};
    np = m_per;
    if (per_lo_we) np = {np[63:32], wdata};
    if (per_hi_we) np = {wdata, np[31:0]};
    ni = hit ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
    no = (hit && m_irq && !irq_clr && m_ovr != 8'd255) ? m_ovr + 8'd1 : m_ovr;
    ns = disarm ? 2'd0 : arm ? 2'd1 : hit ? (rl ? 2'd1 : 2'd2) : m_state;
    if (rst) begin
      ns = 0; ni = 0; nc = 0; np = 0; no = 0;
    end
    @(posedge clk);
    m_state = ns; m_irq = ni; m_cmp = nc; m_per = np; m_ovr = no;
    #1;
    rst = 0; arm = 0; disarm = 0; irq_clr = 0;
    cmp_lo_we = 0; cmp_hi_we = 0; per_lo_we = 0; per_hi_we = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
  endtask

  task automatic wr_cmp(input logic [63:0] v);
    wdata = v[31:0]; cmp_lo_we = 1; tick();
    wdata = v[63:32]; cmp_hi_we = 1; tick();
  endtask

  task automatic wr_per(input logic [63:0] v);
    wdata = v[31:0]; per_lo_we = 1; tick();
    wdata = v[63:32]; per_hi_we = 1; tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({irq, state, cmp_value, overrun} !== {1'b0, 2'd0, 64'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset: got irq=%b state=%0d cmp=%h ovr=%0d, want 0/0/0/0", irq, state, cmp_value, overrun);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    periodic = 0;
    wr_cmp(64'd100);
    timer_value = 64'd10; arm = 1; tick();
    for (int v = 11; v <= 105; v++) begin
      timer_value = 64'(v); tick();
      vectors++;
      if (irq !== (v >= 100)) begin
        errors++;
        $display("FAIL oneshot_irq tv=%0d: got %b want %b", v, irq, (v >= 100));
      end
    end
    vectors++;
    if ({state, overrun} !== {2'd2, 8'd0}) begin
      errors++;
      $display("FAIL oneshot_end: got state=%0d ovr=%0d want 2/0", state, overrun);
    end
  endtask

  task automatic test_periodic();
    logic [63:0] exp_cmp;
    do_reset();
    periodic = 1;
    wr_cmp(64'd50);
    wr_per(64'd20);
    timer_value = 64'd0; arm = 1; tick();
    exp_cmp = 64'd50;
    for (int v = 1; v <= 100; v++) begin
      timer_value = 64'(v); tick();
      if (v == 50 || v == 70 || v == 90) exp_cmp = exp_cmp + 64'd20;
      vectors++;
      if (cmp_value !== exp_cmp) begin
        errors++;
        $display("FAIL periodic_cmp tv=%0d: got %0d want %0d", v, cmp_value, exp_cmp);
      end
      vectors++;
      if ({irq, state, cmp_value, overrun} !== {m_irq, m_state, m_cmp, m_ovr}) begin
        errors++;
        $display("FAIL periodic_model tv=%0d: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                 v, irq, state, cmp_value, overrun, m_irq, m_state, m_cmp, m_ovr);
      end
    end
    vectors++;
    if ({cmp_value, overrun} !== {64'd110, 8'd2}) begin
      errors++;
      $display("FAIL periodic_end: got cmp=%0d ovr=%0d want 110/2", cmp_value, overrun);
    end
  endtask

  task automatic test_late_arm();
    do_reset();
    periodic = 0;
    wr_cmp(64'd5);
    timer_value = 64'd1000; arm = 1; tick();
    vectors++;
    if ({irq, state} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL late_arm_1: got irq=%b state=%0d want 0/1", irq, state);
    end
    timer_value = 64'd1001; tick();
    vectors++;
    if ({irq, state} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL late_arm_2: got irq=%b state=%0d want 1/2", irq, state);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] tv;
    do_reset();
    periodic = 1;
    wr_cmp(64'hFFFF_FFFF_FFFF_FFF0);
    wr_per(64'h20);
    tv = 64'hFFFF_FFFF_FFFF_FFE0;
    timer_value = tv; arm = 1; tick();
    for (int i = 0; i < 64; i++) begin
      tv = tv + 64'd1;
      timer_value = tv; tick();
      vectors++;
      if ({irq, state, cmp_value, overrun} !== {m_irq, m_state, m_cmp, m_ovr}) begin
        errors++;
        $display("FAIL wrap_model tv=%h: got %b/%0d/%h/%0d want %b/%0d/%h/%0d",
                 tv, irq, state, cmp_value, overrun, m_irq, m_state, m_cmp, m_ovr);
      end
      if (tv == 64'hFFFF_FFFF_FFFF_FFEF || tv == 64'h0 || tv == 64'hF) begin
        vectors++;
        if (cmp_value !== ((tv == 64'hFFFF_FFFF_FFFF_FFEF) ? 64'hFFFF_FFFF_FFFF_FFF0 : 64'h10)) begin
          errors++;
          $display("FAIL wrap_hold tv=%h: got cmp=%h", tv, cmp_value);
        end
      end
      if (tv == 64'h10) begin
        vectors++;
        if ({cmp_value, overrun} !== {64'h30, 8'd1}) begin
          errors++;
          $display("FAIL wrap_second_hit: got cmp=%h ovr=%0d want 30/1", cmp_value, overrun);
        end
      end
    end
  endtask

  task automatic test_clr_and_arm_disarm();
    do_reset();
    periodic = 1;
    wr_cmp(64'd10);
    wr_per(64'd5);
    timer_value = 64'd0; arm = 1; tick();
    for (int v = 1; v <= 15; v++) begin
      timer_value = 64'(v);
      if (v == 15) irq_clr = 1;
      tick();
    end
    vectors++;
    if ({irq, overrun, cmp_value} !== {1'b1, 8'd0, 64'd20}) begin
      errors++;
      $display("FAIL clr_collision: got irq=%b ovr=%0d cmp=%0d want 1/0/20", irq, overrun, cmp_value);
    end
    irq_clr = 1; timer_value = 64'd16; tick();
    vectors++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_plain: got irq=%b want 0", irq);
    end
    arm = 1; disarm = 1; tick();
    vectors++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL arm_disarm: got state=%0d want 0", state);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    do_reset();
    periodic = 1;
    wr_per(64'd1);
    timer_value = 64'd0; arm = 1; tick();
    n = 0;
    while (overrun != 8'd3 && n < 20) begin
      timer_value = timer_value + 64'd1; tick();
      n++;
    end
    vectors++;
    if ({irq, state, overrun} !== {1'b1, 2'd1, 8'd3}) begin
      errors++;
      $display("FAIL rst_mid_setup: got irq=%b state=%0d ovr=%0d want 1/1/3", irq, state, overrun);
    end
    rst = 1; arm = 1; irq_clr = 0; timer_value = timer_value + 64'd1; tick();
    vectors++;
    if ({irq, state, cmp_value, overrun} !== {1'b0, 2'd0, 64'd0, 8'd0}) begin
      errors++;
      $display("FAIL rst_mid: got %b/%0d/%h/%0d want 0/0/0/0", irq, state, cmp_value, overrun);
    end
    for (int i = 0; i < 8; i++) begin
      timer_value = 64'(i); tick();
      vectors++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_fire i=%0d: got irq=%b want 0", i, irq);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    timer_value = 64'd0;
    for (int i = 0; i < 3000; i++) begin
      timer_value = timer_value + 64'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) timer_value = {$urandom(), $urandom()};
      wdata    = ($urandom_range(0, 3) == 0) ? $urandom() : timer_value[31:0] + 32'($urandom_range(0, 40));
      r        = $urandom_range(0, 31);
      cmp_lo_we = (r == 0);
      cmp_hi_we = (r == 1);
      per_lo_we = (r == 2);
      per_hi_we = (r == 3);
      if (r == 1 || r == 3) wdata = ($urandom_range(0, 1) == 0) ? timer_value[63:32] : 32'd0;
      if (r == 2) wdata = 32'($urandom_range(0, 12));
      arm      = ($urandom_range(0, 15) == 0);
      disarm   = ($urandom_range(0, 40) == 0);
      irq_clr  = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 400) == 0);
      if ($urandom_range(0, 50) == 0) periodic = ~periodic;
      tick();
      vectors++;
      if ({irq, state, cmp_value, overrun} !== {m_irq, m_state, m_cmp, m_ovr}) begin
        errors++;
        $display("FAIL random i=%0d: got %b/%0d/%h/%0d want %b/%0d/%h/%0d",
                 i, irq, state, cmp_value, overrun, m_irq, m_state, m_cmp, m_ovr);
      end
    end
  endtask

  initial begin
    rst = 1; timer_value = '0; wdata = '0;
    cmp_lo_we = 0; cmp_hi_we = 0; per_lo_we = 0; per_hi_we = 0;
    periodic = 0; arm = 0; disarm = 0; irq_clr = 0;
    m_state = 0; m_irq = 0; m_cmp = 0; m_per = 0; m_ovr = 0;
    #2;
    test_reset();
    test_oneshot();
    test_periodic();
    test_late_arm();
    test_wrap();
    test_clr_and_arm_disarm();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
